// File: rtl/position_tracker_pkg.sv
// rtl/position_tracker_pkg.sv - shared zone encoding and next-zone/step rule for position_tracker_mc
// Contents:
//   zone_t          per-channel hysteresis zone (UNKNOWN, LOW, HIGH)
//   zone_update_t   next zone plus signed count step (-1/0/+1)
//   next_zone_step  zone transition rule from threshold hits and direction
package position_tracker_pkg;

  typedef enum logic [1:0] {
    ZONE_UNKNOWN = 2'd0,
    ZONE_LOW     = 2'd1,
    ZONE_HIGH    = 2'd2
  } zone_t;

  localparam logic signed [1:0] STEP_NONE = 2'sb00;
  localparam logic signed [1:0] STEP_UP   = 2'sb01;
  localparam logic signed [1:0] STEP_DOWN = 2'sb11;

  typedef struct packed {
    zone_t             zone;
    logic signed [1:0] step;
  } zone_update_t;

  // at_upper wins over at_lower so a misconfigured (lower > upper) window
  // still resolves deterministically. Only a LOW<->HIGH transition counts;
  // leaving UNKNOWN just establishes the starting zone.
  function automatic zone_update_t next_zone_step(
    input zone_t zone,
    input logic  at_upper,
    input logic  at_lower,
    input logic  dir
  );
    zone_update_t upd;
    upd.zone = zone;
    upd.step = STEP_NONE;
    if (at_upper) begin
      upd.zone = ZONE_HIGH;
      if (zone == ZONE_LOW) upd.step = dir ? STEP_UP : STEP_DOWN;
    end else if (at_lower) begin
      upd.zone = ZONE_LOW;
      if (zone == ZONE_HIGH) upd.step = dir ? STEP_UP : STEP_DOWN;
    end
    return upd;
  endfunction

endpackage

// File: rtl/position_tracker_mc_if.sv
// rtl/position_tracker_mc_if.sv - AXI-Stream style handshake bundle for position_tracker_mc
// Signals: tvalid, tready, tdata[DATA_WIDTH], tuser[USER_WIDTH]
// Modports: master drives tvalid/tdata/tuser, slave drives tready
interface position_tracker_mc_if #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 2
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [USER_WIDTH-1:0] tuser;

  modport master (output tvalid, output tdata, output tuser, input tready);
  modport slave  (input tvalid, input tdata, input tuser, output tready);
endinterface

// File: rtl/position_tracker_zone.sv
// rtl/position_tracker_zone.sv - combinational hysteresis comparator shared by all channels
// Ports:
//   zone_i    current zone of the selected channel
//   sample_i  signed input sample
//   lower_i   signed lower threshold
//   upper_i   signed upper threshold
//   dir_i     1 = crossings count up, 0 = count down
//   zone_o    next zone
//   step_o    signed count step (-1/0/+1)
module position_tracker_zone
  import position_tracker_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  zone_t                        zone_i,
  input  logic signed [DATA_WIDTH-1:0] sample_i,
  input  logic signed [DATA_WIDTH-1:0] lower_i,
  input  logic signed [DATA_WIDTH-1:0] upper_i,
  input  logic                         dir_i,
  output zone_t                        zone_o,
  output logic signed [1:0]            step_o
);

  zone_update_t upd;

  always_comb begin
    upd    = next_zone_step(zone_i, sample_i >= upper_i, sample_i <= lower_i, dir_i);
    zone_o = upd.zone;
    step_o = upd.step;
  end

endmodule

// File: rtl/position_tracker_mc.sv
// rtl/position_tracker_mc.sv - multi-channel hysteresis fringe counter with registered AXI-Stream output
// Optional feature macro: POSITION_TRACKER_MC_DIR_EN (S_AXIS.tuser MSB selects count direction)
// Ports:
//   SYS_aclk           clock, rising edge
//   SYS_areset         asynchronous active-high reset
//   FC_lower_treshold  signed lower threshold
//   FC_upper_treshold  signed upper threshold
//   FC_clear           one-cycle pulse, clears every channel
//   S_AXIS             slave stream: tdata = sample, tuser = {[dir,] channel}
//   M_AXIS             master stream: tdata = post-update position, tuser = channel
module position_tracker_mc
  import position_tracker_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CHANNEL_COUNT    = 4,
  parameter int CHANNEL_WIDTH    = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1,
  parameter int POSITION_WIDTH   = 32
) (
  input  logic                               SYS_aclk,
  input  logic                               SYS_areset,
  input  logic signed [AXIS_TDATA_WIDTH-1:0] FC_lower_treshold,
  input  logic signed [AXIS_TDATA_WIDTH-1:0] FC_upper_treshold,
  input  logic                               FC_clear,
  position_tracker_mc_if.slave               S_AXIS,
  position_tracker_mc_if.master              M_AXIS
);

  logic [CHANNEL_WIDTH-1:0] tag;
  logic                     dir;

  assign tag = S_AXIS.tuser[CHANNEL_WIDTH-1:0];
`ifdef POSITION_TRACKER_MC_DIR_EN
  assign dir = S_AXIS.tuser[CHANNEL_WIDTH];
`else
  assign dir = 1'b1;
`endif

  zone_t                     zone_q  [CHANNEL_COUNT];
  zone_t                     zone_d  [CHANNEL_COUNT];
  logic [POSITION_WIDTH-1:0] count_q [CHANNEL_COUNT];
  logic [POSITION_WIDTH-1:0] count_d [CHANNEL_COUNT];

  logic                      m_valid_q, m_valid_d;
  logic [POSITION_WIDTH-1:0] m_data_q,  m_data_d;
  logic [CHANNEL_WIDTH-1:0]  m_user_q,  m_user_d;

  logic s_ready;
  logic accept;

  assign s_ready = !m_valid_q || M_AXIS.tready;
  assign accept  = S_AXIS.tvalid && s_ready;

  assign S_AXIS.tready = s_ready;
  assign M_AXIS.tvalid = m_valid_q;
  assign M_AXIS.tdata  = m_data_q;
  assign M_AXIS.tuser  = m_user_q;

  // Tag mux into the single shared comparator. A clear in the same cycle
  // presents the cleared state so the sample is judged against it.
  logic                      tag_hit;
  zone_t                     cur_zone;
  logic [POSITION_WIDTH-1:0] cur_count;

  always_comb begin
    tag_hit   = 1'b0;
    cur_zone  = ZONE_UNKNOWN;
    cur_count = '0;
    for (int ch = 0; ch < CHANNEL_COUNT; ch++) begin
      if (tag == CHANNEL_WIDTH'(ch)) begin
        tag_hit   = 1'b1;
        cur_zone  = zone_q[ch];
        cur_count = count_q[ch];
      end
    end
    if (FC_clear) begin
      cur_zone  = ZONE_UNKNOWN;
      cur_count = '0;
    end
  end

  zone_t             next_zone;
  logic signed [1:0] step;

  position_tracker_zone #(
    .DATA_WIDTH(AXIS_TDATA_WIDTH)
  ) u_zone (
    .zone_i   (cur_zone),
    .sample_i ($signed(S_AXIS.tdata)),
    .lower_i  (FC_lower_treshold),
    .upper_i  (FC_upper_treshold),
    .dir_i    (dir),
    .zone_o   (next_zone),
    .step_o   (step)
  );

  // Plain modular add/subtract: wraps max-positive <-> min-negative.
  logic [POSITION_WIDTH-1:0] new_count;

  always_comb begin
    case (step)
      STEP_UP:   new_count = cur_count + POSITION_WIDTH'(1);
      STEP_DOWN: new_count = cur_count - POSITION_WIDTH'(1);
      default:   new_count = cur_count;
    endcase
  end

  always_comb begin
    zone_d    = zone_q;
    count_d   = count_q;
    m_valid_d = m_valid_q && !M_AXIS.tready;
    m_data_d  = m_data_q;
    m_user_d  = m_user_q;

    if (FC_clear) begin
      for (int ch = 0; ch < CHANNEL_COUNT; ch++) begin
        zone_d[ch]  = ZONE_UNKNOWN;
        count_d[ch] = '0;
      end
    end

    if (accept) begin
      for (int ch = 0; ch < CHANNEL_COUNT; ch++) begin
        if (tag == CHANNEL_WIDTH'(ch)) begin
          zone_d[ch]  = next_zone;
          count_d[ch] = new_count;
        end
      end
      // Out-of-range tags still produce a beat, but it reports 0.
      m_valid_d = 1'b1;
      m_data_d  = tag_hit ? new_count : '0;
      m_user_d  = tag;
    end
  end

  always_ff @(posedge SYS_aclk or posedge SYS_areset) begin
    if (SYS_areset) begin
      for (int ch = 0; ch < CHANNEL_COUNT; ch++) begin
        zone_q[ch]  <= ZONE_UNKNOWN;
        count_q[ch] <= '0;
      end
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_user_q  <= '0;
    end else begin
      zone_q    <= zone_d;
      count_q   <= count_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_user_q  <= m_user_d;
    end
  end

endmodule

// File: tb/tb_position_tracker_mc.sv
// tb/tb_position_tracker_mc.sv - scoreboard bench for position_tracker_mc (default and narrow-counter instances)
module tb_position_tracker_mc;

`ifdef POSITION_TRACKER_MC_DIR_EN
  localparam int SU_W = 3;
`else
  localparam int SU_W = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic signed [31:0] lo, up;
  logic               fc_clear;
  logic               m_ready;
  bit                 rand_ready;

  position_tracker_mc_if #(.DATA_WIDTH(32), .USER_WIDTH(SU_W)) sa ();
  position_tracker_mc_if #(.DATA_WIDTH(32), .USER_WIDTH(2))    ma ();
  position_tracker_mc_if #(.DATA_WIDTH(32), .USER_WIDTH(SU_W)) sb ();
  position_tracker_mc_if #(.DATA_WIDTH(4),  .USER_WIDTH(2))    mb ();

  assign sb.tvalid = sa.tvalid;
  assign sb.tdata  = sa.tdata;
  assign sb.tuser  = sa.tuser;
  assign ma.tready = m_ready;
  assign mb.tready = m_ready;

  // dut_a: default build. dut_b: 3 channels (tag 3 is out of range) and a
  // 4-bit counter so wrap-around happens within a short run.
  position_tracker_mc dut_a (
    .SYS_aclk          (clk),
    .SYS_areset        (rst),
    .FC_lower_treshold (lo),
    .FC_upper_treshold (up),
    .FC_clear          (fc_clear),
    .S_AXIS            (sa),
    .M_AXIS            (ma)
  );

  position_tracker_mc #(.CHANNEL_COUNT(3), .POSITION_WIDTH(4)) dut_b (
    .SYS_aclk          (clk),
    .SYS_areset        (rst),
    .FC_lower_treshold (lo),
    .FC_upper_treshold (up),
    .FC_clear          (fc_clear),
    .S_AXIS            (sb),
    .M_AXIS            (mb)
  );

  // Reference model: zone 0 = unknown, 1 = below window, 2 = above window.
  int     zone_m [2][4];
  longint cnt_m  [2][4];
  int     cc_m   [2] = '{4, 3};
  longint mask_m [2] = '{64'hFFFF_FFFF, 64'hF};

  typedef struct { int ch; longint val; } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  int cmp_n = 0;
  int err_n = 0;

  function automatic void model_clear();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++) begin
        zone_m[d][c] = 0;
        cnt_m[d][c]  = 0;
      end
  endfunction

  function automatic longint model_sample(input int d, input int ch, input int s,
                                          input int lth, input int uth, input bit dn);
    longint delta;
    if (ch >= cc_m[d]) return 0;
    delta = dn ? -1 : 1;
    if (s >= uth) begin
      if (zone_m[d][ch] == 1) cnt_m[d][ch] = (cnt_m[d][ch] + delta) & mask_m[d];
      zone_m[d][ch] = 2;
    end else if (s <= lth) begin
      if (zone_m[d][ch] == 2) cnt_m[d][ch] = (cnt_m[d][ch] + delta) & mask_m[d];
      zone_m[d][ch] = 1;
    end
    return cnt_m[d][ch];
  endfunction

  function automatic void check(input string name, input longint act, input longint exp);
    cmp_n++;
    if (act != exp) begin
      err_n++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  task automatic send(input int ch, input int s, input bit dir, input bit clr);
    bit       done;
    bit       down;
    logic [2:0] u;
    int       cc;
    done = 1'b0;
`ifdef POSITION_TRACKER_MC_DIR_EN
    down = !dir;
`else
    down = 1'b0;
`endif
    cc = ch;
    u  = {dir, cc[1:0]};
    @(negedge clk);
    sa.tvalid = 1'b1;
    sa.tdata  = s;
    sa.tuser  = u[SU_W-1:0];
    fc_clear  = clr;
    for (int t = 0; t < 64 && !done; t++) begin
      #1;
      if (fc_clear) model_clear();
      if (sa.tready) begin
        qa.push_back('{ch, model_sample(0, ch, s, lo, up, down)});
        qb.push_back('{ch, model_sample(1, ch, s, lo, up, down)});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      fc_clear = 1'b0;
      if (!done) @(negedge clk);
    end
    sa.tvalid = 1'b0;
    if (!done) begin
      cmp_n++;
      err_n++;
      $display("FAIL send_timeout: sample ch %0d not accepted within 64 cycles", ch);
    end
  endtask

  always @(negedge clk) if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);

  // Monitor: a presented beat must match the queue head every cycle it is
  // held (covers stability under back-pressure); it retires on handshake.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (ma.tvalid) begin
        if (qa.size() == 0) begin
          cmp_n++; err_n++;
          $display("FAIL beat_a: unexpected beat data %0d, none expected", ma.tdata);
        end else begin
          check("beat_a_data", longint'(ma.tdata), qa[0].val);
          check("beat_a_user", longint'(ma.tuser), longint'(qa[0].ch));
          if (m_ready) qa.delete(0);
        end
      end
      if (mb.tvalid) begin
        if (qb.size() == 0) begin
          cmp_n++; err_n++;
          $display("FAIL beat_b: unexpected beat data %0d, none expected", mb.tdata);
        end else begin
          check("beat_b_data", longint'(mb.tdata), qb[0].val);
          check("beat_b_user", longint'(mb.tuser), longint'(qb[0].ch));
          if (m_ready) qb.delete(0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; fc_clear = 1'b0; m_ready = 1'b1; rand_ready = 1'b0;
    lo = -10; up = 10;
    sa.tvalid = 1'b0; sa.tdata = '0; sa.tuser = '0;
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    check("reset_m_tvalid", ma.tvalid, 0);
    check("reset_m_tdata",  ma.tdata, 0);
    check("reset_m_tuser",  ma.tuser, 0);
    check("reset_s_tready", sa.tready, 1);
    check("reset_b_tvalid", mb.tvalid, 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic hysteresis trace on channel 0.
    send(0, -5, 1, 0); send(0, 10, 1, 0); send(0, 5, 1, 0);
    send(0, -10, 1, 0); send(0, 15, 1, 0); send(0, -15, 1, 0);

    // Channels 0 and 1 in opposite phase.
    for (int i = 0; i < 8; i++) begin
      send(0, (i % 2) ? 12 : -12, 1, 0);
      send(1, (i % 2) ? -12 : 12, 1, 0);
    end

    // Clear together with a sample, then a crossing from the new HIGH zone.
    send(0, 15, 1, 1);
    send(0, -10, 1, 0);

    // Back-pressure: one beat fills the output register, then ready drops.
    repeat (2) @(negedge clk);
    m_ready = 1'b0;
    send(2, -20, 1, 0);
    check("stall_s_tready", sa.tready, 0);
    fork
      begin
        repeat (5) @(negedge clk);
        m_ready = 1'b1;
      end
    join_none
    send(2, 20, 1, 0);
    send(2, -20, 1, 0);
    send(3, 20, 1, 0);

    // Asynchronous reset with a beat pending; channel 0 left in LOW.
    repeat (2) @(negedge clk);
    m_ready = 1'b0;
    send(0, -15, 1, 0);
    @(posedge clk);
    #3;
    check("pre_reset_tvalid", ma.tvalid, 1);
    rst = 1'b1;
    #1;
    check("async_reset_a_tvalid", ma.tvalid, 0);
    check("async_reset_b_tvalid", mb.tvalid, 0);
    qa.delete(); qb.delete();
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b1;
    send(0, 15, 1, 0);
    send(0, -15, 1, 0);

    // Randomised traffic with random back-pressure, clears and thresholds.
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        lo = int'($urandom_range(0, 20)) - 10;
        up = int'($urandom_range(0, 20)) - 10;
      end
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send(int'($urandom_range(0, 3)), int'($urandom_range(0, 40)) - 20,
           bit'($urandom_range(0, 1)), $urandom_range(0, 49) == 0);
    end
    rand_ready = 1'b0;
    @(negedge clk);
    m_ready = 1'b1;
    repeat (6) @(negedge clk);
    #3;
    check("drain_a_queue", qa.size(), 0);
    check("drain_b_queue", qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
